// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational rv32i ALU between NUM_REQ requesters.
// Latency: accept edge E0 -> o_rsp_valid high after E0+1; at least 3 cycles per request.
// Backpressure: o_rsp_* held until i_rsp_ready; no request is accepted while a response is pending.
//
// Ports:
//   i_clk, i_rst_n                     clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready          per-requester handshake; ready is one-hot or zero
//   i_req_operand_a/_b, i_req_alu_op   per-requester operands and operation
//   o_operand_a/_b, o_alu_op           registered operands driving the shared ALU
//   i_alu_data                         combinational ALU result from o_operand_*/o_alu_op
//   o_rsp_valid/_id/_data, i_rsp_ready response to the owning requester

package alu_share_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10
    } ALUSel_e;

endpackage

module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,

    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ-1:0][31:0]   i_req_operand_a,
    input  logic [NUM_REQ-1:0][31:0]   i_req_operand_b,
    input  ALUSel_e [NUM_REQ-1:0]      i_req_alu_op,

    output logic [31:0]                o_operand_a,
    output logic [31:0]                o_operand_b,
    output ALUSel_e                    o_alu_op,
    input  logic [31:0]                i_alu_data,

    output logic                       o_rsp_valid,
    output logic [IDX_W-1:0]           o_rsp_id,
    output logic [31:0]                o_rsp_data,
    input  logic                       i_rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_vld;
    logic [IDX_W-1:0]  next_ptr;

    // Round-robin search starting at rr_ptr. Walking the offsets from the
    // farthest to the nearest lets the nearest valid requester win without
    // a priority-encoder break. The candidate carries one extra bit so the
    // modulo wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        logic [IDX_W:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (i_req_valid[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves to just past the winner so it has lowest priority next time.
    always_comb begin
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + IDX_W'(1);
        end
    end

    // Ready only in IDLE and never while reset is asserted, so a requester
    // cannot believe it was accepted by a block that is being cleared.
    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && (state == ST_IDLE) && grant_vld) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            o_operand_a <= '0;
            o_operand_b <= '0;
            o_alu_op    <= ALU_ADD;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        o_operand_a <= i_req_operand_a[grant_idx];
                        o_operand_b <= i_req_operand_b[grant_idx];
                        o_alu_op    <= i_req_alu_op[grant_idx];
                        o_rsp_id    <= grant_idx;
                        rr_ptr      <= next_ptr;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable for a full cycle here.
                    o_rsp_data  <= i_alu_data;
                    o_rsp_valid <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the handshake.
    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));

    a_no_accept_during_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_rsp_valid |-> (o_req_ready == '0));

    a_rsp_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_rsp_valid && !i_rsp_ready) |=> (o_rsp_valid && $stable(o_rsp_id) && $stable(o_rsp_data)));

endmodule
